// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: latches nothing but state and NZCV flags,
// decodes the current instruction fields and sequences the shared datapath.
module multicycle_controller #(
  parameter logic [3:0]  PC_REG  = 4'd15,
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [11:0]        ToControler,
  input  logic [3:0]         Rd,
  input  logic [3:0]         Flags,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [3:0]         ALUControl,
  output logic [1:0]         RegSrc,
  output logic [1:0]         ImmSrc,
  output logic               RegWrite,
  output logic               illegal,
  output logic [STATE_W-1:0] state_dbg
);

  typedef enum logic [STATE_W-1:0] {
    FETCH  = STATE_W'(0),
    DECODE = STATE_W'(1),
    MEMADR = STATE_W'(2),
    MEMRD  = STATE_W'(3),
    MEMWB  = STATE_W'(4),
    MEMWR  = STATE_W'(5),
    EXECR  = STATE_W'(6),
    EXECI  = STATE_W'(7),
    ALUWB  = STATE_W'(8),
    BRANCH = STATE_W'(9)
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_ORR = 4'b0011,
    ALU_EOR = 4'b0100
  } alu_t;

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;  // {N,Z,C,V}

  logic [3:0] cond;
  logic [1:0] op;
  logic       funct_i;
  logic [3:0] cmd;
  logic       funct_s;

  assign cond    = ToControler[11:8];
  assign op      = ToControler[7:6];
  assign funct_i = ToControler[5];
  assign cmd     = ToControler[4:1];
  assign funct_s = ToControler[0];

  // Condition-code evaluation against the architectural flags.
  function automatic logic cond_ex(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = !z;
      4'b0010: cond_ex = cf;
      4'b0011: cond_ex = !cf;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = !n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = !v;
      4'b1000: cond_ex = cf && !z;
      4'b1001: cond_ex = !cf || z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = !z && (n == v);
      4'b1101: cond_ex = z || (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  endfunction

  logic cond_ok;
  assign cond_ok = cond_ex(cond, flags_q);

  // Data-processing command decode: ALU operation, logic-op and compare tags.
  alu_t dp_alu;
  logic dp_logic;
  logic dp_cmp;
  always_comb begin
    dp_alu   = ALU_ADD;
    dp_logic = 1'b0;
    dp_cmp   = 1'b0;
    case (cmd)
      4'b0100: dp_alu = ALU_ADD;
      4'b0010: dp_alu = ALU_SUB;
      4'b1010: begin
        dp_alu = ALU_SUB;
        dp_cmp = 1'b1;
      end
      4'b0000: begin
        dp_alu   = ALU_AND;
        dp_logic = 1'b1;
      end
      4'b1100: begin
        dp_alu   = ALU_ORR;
        dp_logic = 1'b1;
      end
      4'b0001: begin
        dp_alu   = ALU_EOR;
        dp_logic = 1'b1;
      end
      default: dp_alu = ALU_ADD;
    endcase
  end

  // State and flag registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FETCH;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  // Flag update: only on the execute edge, when S is set or the command is CMP.
  always_comb begin
    flags_d = flags_q;
    if ((state_q == EXECR || state_q == EXECI) && (funct_s || dp_cmp)) begin
      if (dp_logic) flags_d = {Flags[3:2], flags_q[1:0]};
      else          flags_d = Flags;
    end
  end

  // Next state and per-state control outputs; everything stays idle while reset is low.
  always_comb begin
    state_d    = FETCH;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    RegSrc     = 2'b00;
    RegWrite   = 1'b0;
    illegal    = 1'b0;
    if (reset) begin
      case (state_q)
        FETCH: begin
          IRWrite   = 1'b1;
          ALUSrcA   = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          PCWrite   = 1'b1;
          state_d   = DECODE;
        end
        DECODE: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          illegal = (op == 2'b11);
          if (!cond_ok || op == 2'b11) state_d = FETCH;
          else if (op == 2'b00)        state_d = funct_i ? EXECI : EXECR;
          else if (op == 2'b01)        state_d = MEMADR;
          else                         state_d = BRANCH;
        end
        MEMADR: begin
          ALUSrcB = 2'b01;
          state_d = funct_s ? MEMRD : MEMWR;
        end
        MEMRD: begin
          AdrSrc  = 1'b1;
          state_d = MEMWB;
        end
        MEMWB: begin
          ResultSrc = 2'b01;
          RegWrite  = 1'b1;
          PCWrite   = (Rd == PC_REG);
          state_d   = FETCH;
        end
        MEMWR: begin
          AdrSrc   = 1'b1;
          MemWrite = 1'b1;
          RegSrc   = 2'b10;
          state_d  = FETCH;
        end
        EXECR, EXECI: begin
          ALUSrcB    = (state_q == EXECI) ? 2'b01 : 2'b00;
          ALUControl = dp_alu;
          state_d    = dp_cmp ? FETCH : ALUWB;
        end
        ALUWB: begin
          if (Rd == PC_REG) PCWrite  = 1'b1;
          else              RegWrite = 1'b1;
          state_d = FETCH;
        end
        BRANCH: begin
          RegSrc    = 2'b01;
          ALUSrcB   = 2'b01;
          ResultSrc = 2'b10;
          PCWrite   = 1'b1;
          state_d   = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  assign ImmSrc    = op;
  assign state_dbg = state_q;

endmodule
